hilo_muldiv_ctrl: RTL and testbench
===================================

# hilo_muldiv_ctrl

Execute-stage sequencer for the HI/LO register pair and the multi-cycle divider. It decodes the EX-stage ALU op and owns the 64-bit HI/LO state. It launches, holds and cancels the external `div` unit, stalls the pipeline while a division is in flight, and commits multiply, divide and MTHI/MTLO results exactly once per instruction. It sits beside `alu` and replaces the ad-hoc HI/LO and divide logic there.

## Interface
Parameters:
- none; opcode values come from the `EXE_*_OP` macros in `defines.vh`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active low.
- `op_i` in 8: EX-stage ALU op.
- `valid_i` in 1: EX-stage instruction is valid (not a bubble).
- `hold_i` in 1: EX frozen by another hazard source; the same instruction is presented again next cycle.
- `flush_i` in 1: EX instruction is annulled.
- `a_i`, `b_i` in 32: rs and rt operand values.
- `mul_result_i` in 64: product from the combinational multiplier (signedness already applied).
- `div_start_o` out 1: divider start; held high until ready.
- `div_signed_o` out 1: 1 for DIV, 0 for DIVU.
- `div_annul_o` out 1: divider cancel.
- `div_opa_o`, `div_opb_o` out 32: dividend and divisor.
- `div_result_i` in 64: {remainder, quotient}.
- `div_ready_i` in 1: one-cycle result-valid pulse.
- `stall_o` out 1: freeze IF/ID/EX.
- `hi_o`, `lo_o` out 32: registered HI and LO values.

## Operation
- Commit condition `go = valid_i & ~hold_i & ~flush_i`.
- Writes in IDLE when `go`:
  - MULT/MULTU: `{HI,LO} <= mul_result_i`.
  - MTHI: `HI <= a_i`.
  - MTLO: `LO <= a_i`.
  - Any other op: no write.
- FSM states:
  - IDLE:
    - DIV/DIVU with `valid_i & ~flush_i` (hold_i ignored) -> BUSY.
    - Same cycle: `div_start_o=1`, `stall_o=1`, `div_opa_o/opb_o = a_i/b_i`.
    - At the clock edge, latch `a_i`, `b_i`, signedness.
  - BUSY:
    - `div_start_o=1`, `stall_o=1`; operands come from the latches.
    - `flush_i` -> IDLE: `div_annul_o=1` this cycle, no HI/LO write. Flush wins over a simultaneous `div_ready_i`.
    - Else `div_ready_i` -> DONE: `{HI,LO} <= div_result_i`, `stall_o=0` this cycle so the instruction can retire.
  - DONE:
    - `div_start_o=0`, `stall_o=0`.
    - `hold_i` -> stay. The re-presented DIV is not relaunched.
    - Otherwise -> IDLE.
    - `flush_i` -> IDLE (result already committed).
- `div_signed_o` = (op is DIV) in IDLE; latched value in BUSY.
- `div_opa_o`/`div_opb_o` = 0 in DONE.
- Divide by zero: whatever the divider returns is committed unchanged; no trap.
- `hi_o`/`lo_o` reflect writes one cycle after the commit edge. MFHI/MFLO bypass is the forwarding unit's job.

## Timing
- Reset (async, `rst`=0): state IDLE, HI=LO=0, latches 0.
- All outputs after reset: `div_start_o=0`, `div_annul_o=0`, `stall_o=0`, `div_signed_o=0`, operand outputs 0.
- Reset asserted mid-division: the FSM returns to IDLE immediately; the divider is reset by the same `rst`.
- `stall_o`, `div_start_o` and `div_annul_o` are combinational from state and inputs; they have no registered delay.
- Division latency: stall spans from the launch cycle through the cycle before `div_ready_i`. HI/LO update at the edge ending the ready cycle.
- MULT/MTHI/MTLO: single-cycle, no stall; HI/LO are visible at the next cycle.
- A launch in the cycle right after DONE->IDLE is legal (back-to-back DIV).

## Test plan
- Reset, then MTHI `a=0x12345678` and MTLO `a=0x9ABCDEF0` -> `hi_o=0x12345678` and `lo_o=0x9ABCDEF0` one cycle later; `stall_o` never asserted.
- MULT with `mul_result_i=0xFFFFFFFF_FFFFFFF2` (-2*7) -> `hi_o=0xFFFFFFFF`, `lo_o=0xFFFFFFF2`; repeat with `hold_i=1` for 3 cycles -> value unchanged and written once.
- DIV 7 / -2 (divider model, 34-cycle latency) -> `stall_o` high for 34 cycles and `div_start_o` held with `div_signed_o=1`. Then `hi_o=0x00000001`, `lo_o=0xFFFFFFFD`; `div_start_o` low in DONE.
- DIVU 0xFFFFFFFF / 2 with `hold_i=1` for 2 cycles after ready -> FSM stays in DONE with no relaunch; `hi_o=1`, `lo_o=0x7FFFFFFF`.
- DIV launched, `flush_i` at cycle 10 -> `div_annul_o` pulses one cycle, FSM goes to IDLE, HI/LO unchanged; `flush_i` coincident with `div_ready_i` -> also no write.
- Async reset pulsed at cycle 5 of a division -> all outputs 0 immediately, `hi_o=lo_o=0`; a following DIVU 9/4 gives `hi_o=1`, `lo_o=2`.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register pair and multi-cycle divider sequencer for the EX stage.
// Commits MULT/MTHI/MTLO in one cycle and runs DIV/DIVU through an external divider.
module hilo_muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  op_i,
    input  logic        valid_i,
    input  logic        hold_i,
    input  logic        flush_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [63:0] mul_result_i,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic        div_annul_o,
    output logic [31:0] div_opa_o,
    output logic [31:0] div_opb_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    // Op encodings matching EXE_*_OP in defines.vh.
    localparam logic [7:0] ExeMthiOp  = 8'b0001_0001;
    localparam logic [7:0] ExeMtloOp  = 8'b0001_0011;
    localparam logic [7:0] ExeMultOp  = 8'b0001_1000;
    localparam logic [7:0] ExeMultuOp = 8'b0001_1001;
    localparam logic [7:0] ExeDivOp   = 8'b0001_1010;
    localparam logic [7:0] ExeDivuOp  = 8'b0001_1011;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic        sgn_q, sgn_d;
    logic        go;
    logic        is_div;

    always_comb begin
        go     = valid_i & ~hold_i & ~flush_i;
        is_div = (op_i == ExeDivOp) || (op_i == ExeDivuOp);

        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sgn_d   = sgn_q;

        div_start_o  = 1'b0;
        div_signed_o = 1'b0;
        div_annul_o  = 1'b0;
        div_opa_o    = '0;
        div_opb_o    = '0;
        stall_o      = 1'b0;

        case (state_q)
            StIdle: begin
                if (go) begin
                    case (op_i)
                        ExeMultOp, ExeMultuOp: {hi_d, lo_d} = mul_result_i;
                        ExeMthiOp:             hi_d = a_i;
                        ExeMtloOp:             lo_d = a_i;
                        default:               ;
                    endcase
                end
                // A held DIV still launches; the divider runs while the other hazard clears.
                if (is_div && valid_i && !flush_i) begin
                    state_d      = StBusy;
                    div_start_o  = 1'b1;
                    div_signed_o = (op_i == ExeDivOp);
                    div_opa_o    = a_i;
                    div_opb_o    = b_i;
                    stall_o      = 1'b1;
                    opa_d        = a_i;
                    opb_d        = b_i;
                    sgn_d        = (op_i == ExeDivOp);
                end
            end
            StBusy: begin
                div_start_o  = 1'b1;
                div_signed_o = sgn_q;
                div_opa_o    = opa_q;
                div_opb_o    = opb_q;
                stall_o      = 1'b1;
                if (flush_i) begin
                    div_annul_o = 1'b1;
                    state_d     = StIdle;
                end else if (div_ready_i) begin
                    {hi_d, lo_d} = div_result_i;
                    stall_o      = 1'b0;
                    state_d      = StDone;
                end
            end
            StDone: begin
                // Staying here while held keeps the re-presented DIV from relaunching.
                if (!hold_i || flush_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            hi_q    <= '0;
            lo_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sgn_q   <= sgn_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Randomized bench for hilo_muldiv_ctrl with a behavioural divider and HI/LO reference model.
module tb_hilo_muldiv_ctrl;

    localparam logic [7:0] OpNop   = 8'h00;
    localparam logic [7:0] OpAnd   = 8'b0010_0100;
    localparam logic [7:0] OpMthi  = 8'b0001_0001;
    localparam logic [7:0] OpMtlo  = 8'b0001_0011;
    localparam logic [7:0] OpMult  = 8'b0001_1000;
    localparam logic [7:0] OpMultu = 8'b0001_1001;
    localparam logic [7:0] OpDiv   = 8'b0001_1010;
    localparam logic [7:0] OpDivu  = 8'b0001_1011;

    logic        clk, rst;
    logic [7:0]  op_i;
    logic        valid_i, hold_i, flush_i;
    logic [31:0] a_i, b_i;
    logic [63:0] mul_result_i;
    logic        div_start_o, div_signed_o, div_annul_o;
    logic [31:0] div_opa_o, div_opb_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        stall_o;
    logic [31:0] hi_o, lo_o;

    int          n_chk = 0;
    int          n_err = 0;
    int          lat = 34;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    hilo_muldiv_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .op_i         (op_i),
        .valid_i      (valid_i),
        .hold_i       (hold_i),
        .flush_i      (flush_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .mul_result_i (mul_result_i),
        .div_start_o  (div_start_o),
        .div_signed_o (div_signed_o),
        .div_annul_o  (div_annul_o),
        .div_opa_o    (div_opa_o),
        .div_opb_o    (div_opb_o),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i),
        .stall_o      (stall_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {remainder, quotient}; divide by zero yields {dividend, all-ones}.
    function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b,
                                            input bit sgn);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Behavioural divider: fixed latency, one-cycle ready pulse, cancelled by annul or reset.
    logic        dv_busy;
    int          dv_cnt;
    logic [63:0] dv_res;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dv_busy      <= 1'b0;
            dv_cnt       <= 0;
            dv_res       <= '0;
            div_ready_i  <= 1'b0;
            div_result_i <= '0;
        end else begin
            div_ready_i <= 1'b0;
            if (dv_busy) begin
                if (div_annul_o) begin
                    dv_busy <= 1'b0;
                end else if (dv_cnt == lat - 1) begin
                    dv_busy      <= 1'b0;
                    div_ready_i  <= 1'b1;
                    div_result_i <= dv_res;
                end else begin
                    dv_cnt <= dv_cnt + 1;
                end
            end else if (div_start_o && !div_ready_i) begin
                dv_busy <= 1'b1;
                dv_cnt  <= 1;
                dv_res  <= div_ref(div_opa_o, div_opb_o, div_signed_o);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_simple(input logic [7:0] op, input logic [31:0] a, input logic [63:0] mul,
                              input bit v, input int hold_n, input bit fl);
        for (int h = 0; h <= hold_n; h++) begin
            @(negedge clk);
            op_i = op; valid_i = v; a_i = a; b_i = $urandom; mul_result_i = mul;
            hold_i = (h < hold_n); flush_i = fl;
            #1;
            chk("simple_stall", stall_o, 0);
            chk("simple_start", div_start_o, 0);
            if (h > 0) begin
                chk("held_hi", hi_o, exp_hi);
                chk("held_lo", lo_o, exp_lo);
            end
        end
        if (v && !fl) begin
            if (op == OpMult || op == OpMultu) {exp_hi, exp_lo} = mul;
            else if (op == OpMthi) exp_hi = a;
            else if (op == OpMtlo) exp_lo = a;
        end
        @(negedge clk);
        op_i = OpNop; valid_i = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
        #1;
        chk("simple_hi", hi_o, exp_hi);
        chk("simple_lo", lo_o, exp_lo);
    endtask

    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int flush_at, input int hold_n);
        logic [63:0] r;
        int          stalls;
        bit          fin;
        bit          flushed;
        r = div_ref(a, b, op == OpDiv);
        @(negedge clk);
        op_i = op; valid_i = 1'b1; a_i = a; b_i = b; hold_i = 1'b0; flush_i = 1'b0;
        #1;
        chk("launch_start", div_start_o, 1);
        chk("launch_signed", div_signed_o, op == OpDiv);
        chk("launch_opa", div_opa_o, a);
        chk("launch_opb", div_opb_o, b);
        stalls = 0; fin = 0; flushed = 0;
        for (int c = 0; c < 300 && !fin; c++) begin
            if (c > 0) begin
                @(negedge clk);
                a_i = $urandom; b_i = $urandom;
                flush_i = (c == flush_at);
                #1;
            end
            if (flush_i) begin
                chk("flush_annul", div_annul_o, 1);
                fin = 1; flushed = 1;
            end else if (stall_o) begin
                stalls++;
                chk("busy_start", div_start_o, 1);
                chk("busy_annul", div_annul_o, 0);
                chk("busy_signed", div_signed_o, op == OpDiv);
                chk("busy_opa", div_opa_o, a);
                chk("busy_opb", div_opb_o, b);
            end else begin
                chk("stall_cycles", stalls, lat);
                {exp_hi, exp_lo} = r;
                fin = 1;
            end
        end
        if (!fin) chk("div_timeout", 0, 1);
        if (flushed) begin
            @(negedge clk);
            op_i = OpNop; valid_i = 1'b0; flush_i = 1'b0;
            #1;
            chk("post_flush_annul", div_annul_o, 0);
            chk("post_flush_stall", stall_o, 0);
            chk("post_flush_hi", hi_o, exp_hi);
            chk("post_flush_lo", lo_o, exp_lo);
        end else begin
            for (int h = 0; h <= hold_n; h++) begin
                @(negedge clk);
                hold_i = (h < hold_n); a_i = $urandom; b_i = $urandom;
                #1;
                chk("done_start", div_start_o, 0);
                chk("done_stall", stall_o, 0);
                chk("done_opa", div_opa_o, 0);
                chk("div_hi", hi_o, exp_hi);
                chk("div_lo", lo_o, exp_lo);
            end
        end
    endtask

    initial begin
        rst = 1'b0; op_i = OpNop; valid_i = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
        a_i = '0; b_i = '0; mul_result_i = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_start", div_start_o, 0);
        chk("rst_annul", div_annul_o, 0);
        chk("rst_signed", div_signed_o, 0);
        chk("rst_opa", div_opa_o, 0);
        rst = 1'b1;

        run_simple(OpMthi, 32'h1234_5678, 64'h0, 1, 0, 0);
        run_simple(OpMtlo, 32'h9ABC_DEF0, 64'h0, 1, 0, 0);
        chk("mthi_value", hi_o, 32'h1234_5678);
        chk("mtlo_value", lo_o, 32'h9ABC_DEF0);

        run_simple(OpMult, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2, 1, 3, 0);
        chk("mult_hi", hi_o, 32'hFFFF_FFFF);
        chk("mult_lo", lo_o, 32'hFFFF_FFF2);

        lat = 34;
        run_div(OpDiv, 32'd7, 32'hFFFF_FFFE, -1, 0);
        chk("div7_hi", hi_o, 32'h1);
        chk("div7_lo", lo_o, 32'hFFFF_FFFD);
        run_div(OpDivu, 32'hFFFF_FFFF, 32'd2, -1, 2);
        chk("divu_hi", hi_o, 32'h1);
        chk("divu_lo", lo_o, 32'h7FFF_FFFF);

        run_div(OpDiv, 32'd100, 32'd7, 10, 0);
        run_div(OpDiv, 32'd5, 32'd3, 34, 0);
        chk("flush_keep_lo", lo_o, 32'h7FFF_FFFF);

        // Reset in the middle of a division.
        @(negedge clk);
        op_i = OpDiv; valid_i = 1'b1; a_i = 32'd50; b_i = 32'd3;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0; valid_i = 1'b0; op_i = OpNop;
        #1;
        exp_hi = '0; exp_lo = '0;
        chk("midrst_start", div_start_o, 0);
        chk("midrst_stall", stall_o, 0);
        chk("midrst_annul", div_annul_o, 0);
        chk("midrst_opa", div_opa_o, 0);
        chk("midrst_hi", hi_o, 0);
        chk("midrst_lo", lo_o, 0);
        @(negedge clk);
        rst = 1'b1;
        run_div(OpDivu, 32'd9, 32'd4, -1, 0);
        chk("div9_hi", hi_o, 32'h1);
        chk("div9_lo", lo_o, 32'h2);

        for (int i = 0; i < 40; i++) begin
            int          sel;
            logic [31:0] a, b;
            logic [7:0]  op;
            sel = $urandom_range(0, 6);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (sel >= 5) begin
                op  = (sel == 5) ? OpDiv : OpDivu;
                lat = $urandom_range(2, 40);
                run_div(op, a, b,
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat)) : -1,
                        $urandom_range(0, 2));
            end else begin
                case (sel)
                    0:       op = OpMthi;
                    1:       op = OpMtlo;
                    2:       op = OpMult;
                    3:       op = OpMultu;
                    default: op = OpAnd;
                endcase
                run_simple(op, a, (op == OpMultu) ? {32'd0, a} * {32'd0, b}
                                                  : 64'($signed(a) * $signed(b)),
                           $urandom_range(0, 3) != 0, $urandom_range(0, 2),
                           $urandom_range(0, 4) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
